scan_addr_decoder: RTL and testbench

SCAN_ADDR_DECODER -- requirements
Module: scan_addr_decoder

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_coord_counter.sv | 69 ++++++
 rtl/scan_addr_decoder.sv | 154 +++++++++++++++
 tb/tb_scan_addr_decoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared widths and state encoding for the scan address decoder.
package scan_pkg;

  localparam int ADDR_W     = 32;
  localparam int STRIDE_X_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } scan_dec_state_t;

endpackage

// File: rtl/scan_coord_counter.sv
// Tracks the (x, y) position of the next expected element and the address
// the scan generator should present for it. All arithmetic wraps mod 2^32.
module scan_coord_counter
  import scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] x_stride_i,
  input  logic [ADDR_W-1:0] y_stride_i,
  input  logic [ADDR_W-1:0] x_max_i,
  input  logic [ADDR_W-1:0] y_max_i,
  output logic [ADDR_W-1:0] x_o,
  output logic [ADDR_W-1:0] y_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              row_last_o,
  output logic              frame_last_o
);

  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign addr_o       = addr_q;
  assign row_last_o   = (x_q == x_max_i);
  assign frame_last_o = row_last_o && (y_q == y_max_i);

  // Next position: column step, row step, or wrap to the frame origin.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (advance_i) begin
      if (frame_last_o) begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
      end else if (row_last_o) begin
        x_d    = '0;
        y_d    = y_q + ADDR_W'(1);
        addr_d = addr_q + y_stride_i;
      end else begin
        x_d    = x_q + ADDR_W'(1);
        addr_d = addr_q + x_stride_i;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/scan_addr_decoder.sv
// Checks a stream of scan addresses against the expected raster sequence and
// turns each matching address into an (x, y) element with row/frame markers.
// A mismatch latches the offending address and parks the block until the
// next start.
module scan_addr_decoder
  import scan_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [STRIDE_X_W-1:0] x_stride,
  input  logic [ADDR_W-1:0]     y_stride,
  input  logic [ADDR_W-1:0]     x_max,
  input  logic [ADDR_W-1:0]     y_max,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_x,
  output logic [ADDR_W-1:0]     out_y,
  output logic                  out_row_last,
  output logic                  out_frame_last,
  output logic                  err,
  output logic [ADDR_W-1:0]     err_addr
);

  scan_dec_state_t       state_q, state_d;
  logic [STRIDE_X_W-1:0] xs_q, xs_d;
  logic [ADDR_W-1:0]     ys_q, ys_d;
  logic [ADDR_W-1:0]     xm_q, xm_d;
  logic [ADDR_W-1:0]     ym_q, ym_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]     out_x_q, out_x_d;
  logic [ADDR_W-1:0]     out_y_q, out_y_d;
  logic                  out_rl_q, out_rl_d;
  logic                  out_fl_q, out_fl_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;

  logic                  xfer;
  logic                  advance;
  logic [ADDR_W-1:0]     cnt_x, cnt_y, cnt_addr;
  logic                  cnt_rl, cnt_fl;

  // Outside RUN the decoder swallows whatever arrives; in RUN it only
  // accepts when the output register is free or being emptied this cycle.
  assign in_ready = (state_q == RUN) ? (!out_valid_q || out_ready) : 1'b1;
  assign xfer     = in_valid && in_ready;

  assign out_valid      = out_valid_q;
  assign out_x          = out_x_q;
  assign out_y          = out_y_q;
  assign out_row_last   = out_rl_q;
  assign out_frame_last = out_fl_q;
  assign err            = err_q;
  assign err_addr       = err_addr_q;

  scan_coord_counter u_counter (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start),
    .advance_i    (advance),
    .x_stride_i   ({{(ADDR_W-STRIDE_X_W){1'b0}}, xs_q}),
    .y_stride_i   (ys_q),
    .x_max_i      (xm_q),
    .y_max_i      (ym_q),
    .x_o          (cnt_x),
    .y_o          (cnt_y),
    .addr_o       (cnt_addr),
    .row_last_o   (cnt_rl),
    .frame_last_o (cnt_fl)
  );

  // Next state, output register and error capture; start overrides any
  // transfer in the same cycle.
  always_comb begin
    state_d     = state_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    xm_d        = xm_q;
    ym_d        = ym_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_rl_d    = out_rl_q;
    out_fl_d    = out_fl_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    advance     = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (start) begin
      state_d     = RUN;
      xs_d        = x_stride;
      ys_d        = y_stride;
      xm_d        = x_max;
      ym_d        = y_max;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      err_addr_d  = '0;
    end else if ((state_q == RUN) && xfer) begin
      if (in_addr == cnt_addr) begin
        advance     = 1'b1;
        out_valid_d = 1'b1;
        out_x_d     = cnt_x;
        out_y_d     = cnt_y;
        out_rl_d    = cnt_rl;
        out_fl_d    = cnt_fl;
      end else begin
        // Any pending element was accepted this cycle (in_ready implies it),
        // so the output register simply drains.
        state_d    = ERR;
        err_d      = 1'b1;
        err_addr_d = in_addr;
      end
    end
  end

  // Control, config and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      xs_q        <= '0;
      ys_q        <= '0;
      xm_q        <= '0;
      ym_q        <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_rl_q    <= 1'b0;
      out_fl_q    <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      xm_q        <= xm_d;
      ym_q        <= ym_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_rl_q    <= out_rl_d;
      out_fl_q    <= out_fl_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_scan_addr_decoder.sv
// Scoreboard bench for scan_addr_decoder: the driver predicts each element
// from a raster-position model and queues it; the monitor pops and compares.
module tb_scan_addr_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x_stride = '0;
  logic [31:0] y_stride = '0;
  logic [31:0] x_max = '0;
  logic [31:0] y_max = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_x, out_y;
  logic        out_row_last, out_frame_last, err;
  logic [31:0] err_addr;

  scan_addr_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .x_stride       (x_stride),
    .y_stride       (y_stride),
    .x_max          (x_max),
    .y_max          (y_max),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_x          (out_x),
    .out_y          (out_y),
    .out_row_last   (out_row_last),
    .out_frame_last (out_frame_last),
    .err            (err),
    .err_addr       (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        rl;
    logic        fl;
  } elem_t;

  elem_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: mode 0 idle, 1 run, 2 error; k = element index in frame.
  int          m_mode = 0;
  int unsigned m_k = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_err_addr = '0;
  logic [31:0] m_xs = '0, m_ys = '0, m_xm = '0, m_ym = '0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned m_frame_len();
    return (m_xm + 1) * (m_ym + 1);
  endfunction

  // Raster address: each full row contributes x_max column steps plus one row step.
  function automatic logic [31:0] m_addr(input int unsigned k);
    logic [31:0] x, y;
    x = k % (m_xm + 1);
    y = k / (m_xm + 1);
    return y * (m_xm * m_xs + m_ys) + x * m_xs;
  endfunction

  function automatic elem_t m_elem(input int unsigned k);
    elem_t e;
    e.x  = k % (m_xm + 1);
    e.y  = k / (m_xm + 1);
    e.rl = (e.x == m_xm);
    e.fl = (e.x == m_xm) && (e.y == m_ym);
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_k = 0; m_err = 1'b0; m_err_addr = '0;
    m_xs = '0; m_ys = '0; m_xm = '0; m_ym = '0;
  endtask

  // Monitor: every presented element must be the oldest predicted one.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (out_valid && q.size() > 0) begin
        chk("out_x", out_x, q[0].x);
        chk("out_y", out_y, q[0].y);
        chk("row_last", {31'b0, out_row_last}, {31'b0, q[0].rl});
        chk("frame_last", {31'b0, out_frame_last}, {31'b0, q[0].fl});
        if (out_ready) void'(q.pop_front());
      end
      chk("err", {31'b0, err}, {31'b0, m_err});
      chk("err_addr", err_addr, m_err_addr);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // One clock: predict the effect of the upcoming edge, then advance to it.
  task automatic cycle(output bit acc);
    @(negedge clk); #1;
    acc = in_valid && in_ready;
    chk("in_ready", {31'b0, in_ready},
        {31'b0, (m_mode != 1) || (q.size() == 0) || out_ready});
    if (start) begin
      m_xs = {16'b0, x_stride}; m_ys = y_stride; m_xm = x_max; m_ym = y_max;
      m_mode = 1; m_k = 0; m_err = 1'b0; m_err_addr = '0;
      q.delete();
    end else if (acc && m_mode == 1) begin
      if (in_addr == m_addr(m_k)) begin
        q.push_back(m_elem(m_k));
        m_k = (m_k + 1) % m_frame_len();
      end else begin
        m_err = 1'b1; m_err_addr = in_addr; m_mode = 2;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cycle(acc);
  endtask

  task automatic send(input logic [31:0] a);
    bit acc;
    in_valid = 1'b1;
    in_addr  = a;
    acc      = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) cycle(acc);
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: addr %h not accepted within 64 cycles", a);
    end
    in_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] xs, input logic [31:0] ys,
                         input logic [31:0] xm, input logic [31:0] ym);
    x_stride = xs; y_stride = ys; x_max = xm; y_max = ym;
  endtask

  // Start a frame, then scramble the config inputs: only the latched copy counts.
  task automatic do_start(input logic [15:0] xs, input logic [31:0] ys,
                          input logic [31:0] xm, input logic [31:0] ym);
    bit acc;
    set_cfg(xs, ys, xm, ym);
    start = 1'b1;
    cycle(acc);
    start = 1'b0;
    set_cfg(16'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [31:0] a;
    int n;

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_row_last", {31'b0, out_row_last}, 0);
    chk("rst_frame_last", {31'b0, out_frame_last}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    rst = 1'b0;

    // IDLE swallows addresses without producing output.
    send(32'd5);
    send(32'd0);
    idle(2);

    // 4x2 frame with unit strides.
    do_start(16'd1, 32'd1, 32'd3, 32'd1);
    for (int i = 0; i < 8; i++) send(i);
    drain();

    // Distinct strides, then the next frame starts at address 0.
    do_start(16'd4, 32'd100, 32'd1, 32'd1);
    send(32'd0); send(32'd4); send(32'd104); send(32'd108); send(32'd0);
    drain();

    // Backpressure: element (0,0) held while in_ready stays low.
    do_start(16'd1, 32'd1, 32'd3, 32'd1);
    out_ready = 1'b0;
    send(32'd0);
    in_valid = 1'b1;
    in_addr  = 32'd1;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      chk("stall_no_accept", {31'b0, acc}, 0);
    end
    out_ready = 1'b1;
    send(32'd1); send(32'd2); send(32'd3);
    drain();

    // Mismatch on the third address.
    do_start(16'd1, 32'd1, 32'd3, 32'd1);
    send(32'd0); send(32'd1); send(32'd7); send(32'd3); send(32'd4);
    drain();
    chk("err_set", {31'b0, err}, 1);
    chk("err_addr_7", err_addr, 32'd7);
    do_start(16'd1, 32'd1, 32'd3, 32'd1);
    chk("err_cleared", {31'b0, err}, 0);
    send(32'd0);
    drain();

    // Asynchronous reset with an element pending.
    do_start(16'd1, 32'd1, 32'd3, 32'd1);
    out_ready = 1'b0;
    send(32'd0);
    chk("pre_rst_valid", {31'b0, out_valid}, 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    do_start(16'd1, 32'd1, 32'd3, 32'd1);
    send(32'd0);
    drain();

    // Zero-extended 16-bit stride and 32-bit wrap.
    do_start(16'hFFFF, 32'd1, 32'd1, 32'd0);
    send(32'd0); send(32'h0000_FFFF); send(32'd0); send(32'h0000_FFFF);
    drain();
    do_start(16'hFFFF, 32'hFFFF_0002, 32'd1, 32'd1);
    send(32'd0); send(32'h0000_FFFF); send(32'd1); send(32'h0001_0000); send(32'd0);
    drain();

    // Single-element frame: every element is row and frame last at address 0.
    do_start(16'd5, 32'd7, 32'd0, 32'd0);
    send(32'd0); send(32'd0); send(32'd0); send(32'd5);
    drain();

    // Start coincident with a transfer while an element is pending.
    do_start(16'd1, 32'd1, 32'd3, 32'd1);
    out_ready = 1'b0;
    send(32'd0);
    set_cfg(16'd1, 32'd1, 32'd3, 32'd1);
    start    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 32'd1;
    cycle(acc);
    start    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(32'd0); send(32'd1);
    drain();

    // Randomized frames with random backpressure and occasional bad addresses.
    for (int r = 0; r < 30; r++) begin
      do_start(16'($urandom), $urandom, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
      rand_rdy = 1'b1;
      n = $urandom_range(5, 24);
      for (int i = 0; i < n; i++) begin
        a = m_addr(m_k);
        if ($urandom_range(0, 24) == 0) a = a ^ ($urandom | 32'd1);
        send(a);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
